tile_c_buffer: RTL and testbench

Ping-pong output tile buffer directly downstream of `TMUL_FP16_16_32`. It captures the 512-bit `RowProduct` rows (32 FP16 lanes each) into a 16-row tile C. It releases each completed tile row-by-row to the writeback path over a valid/ready handshake. Two banks let the multiplier fill one tile while the previous tile drains.

---
 rtl/tile_c_buffer_if.sv | 31 +++
 rtl/tile_c_buffer.sv | 120 ++++++++++++
 tb/tb_tile_c_buffer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/tile_c_buffer_if.sv
// Row handshake bundle between the TMUL row producer, tile_c_buffer and the
// writeback consumer.
//   in_valid/in_row/in_ready       : row product from TMUL into the buffer
//   out_valid/out_row/out_ready    : completed-tile row toward writeback
//   out_idx/out_last               : row position of out_row within its tile
// Modports: master = producer/consumer side (testbench), slave = buffer.
interface tile_c_buffer_if #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned ROW_W = 512
);
  localparam int unsigned IDX_W = $clog2(ROWS);

  logic             in_valid;
  logic [ROW_W-1:0] in_row;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [ROW_W-1:0] out_row;
  logic [IDX_W-1:0] out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, out_idx, out_last
  );
endinterface

// File: rtl/tile_c_buffer.sv
// Ping-pong tile C buffer: captures TMUL row products into one of two
// ROWS-deep banks and drains completed tiles row-by-row, in fill order.
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   clear      : synchronous flush of both banks (tiles_done untouched)
//   bus        : row handshake bundle (slave modport)
//   tiles_done : count of fully drained tiles, wraps at 2^16
module tile_c_buffer #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned ROW_W = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  tile_c_buffer_if.slave        bus,
  output logic [15:0]           tiles_done
);
  localparam int unsigned IDX_W = $clog2(ROWS);
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bankState_e;

  bankState_e       bankState     [2];
  bankState_e       bankStateNext [2];
  logic             wrBank, wrBankNext;
  logic             rdBank, rdBankNext;
  logic [IDX_W-1:0] wrRow, wrRowNext;
  logic [IDX_W-1:0] rdRow, rdRowNext;
  logic [15:0]      tilesDoneNext;

  logic             inReady, outValid, inXfer, outXfer, memWe;
  logic [ROW_W-1:0] mem [2][ROWS];

  // Handshake qualifiers derive only from registered bank state.
  assign inReady  = (bankState[wrBank] == EMPTY) || (bankState[wrBank] == FILLING);
  assign outValid = (bankState[rdBank] == FULL)  || (bankState[rdBank] == DRAINING);
  assign inXfer   = bus.in_valid && inReady;
  assign outXfer  = outValid && bus.out_ready;
  assign memWe    = inXfer && !clear;

  assign bus.in_ready  = inReady;
  assign bus.out_valid = outValid;
  assign bus.out_row   = mem[rdBank][rdRow];
  assign bus.out_idx   = rdRow;
  assign bus.out_last  = outValid && (rdRow == LAST_ROW);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bankState[0] <= EMPTY;
      bankState[1] <= EMPTY;
      wrBank       <= 1'b0;
      rdBank       <= 1'b0;
      wrRow        <= '0;
      rdRow        <= '0;
      tiles_done   <= '0;
    end else begin
      bankState[0] <= bankStateNext[0];
      bankState[1] <= bankStateNext[1];
      wrBank       <= wrBankNext;
      rdBank       <= rdBankNext;
      wrRow        <= wrRowNext;
      rdRow        <= rdRowNext;
      tiles_done   <= tilesDoneNext;
    end
  end

  // Next-state logic. A bank being written is EMPTY/FILLING and a bank being
  // read is FULL/DRAINING, so both updates never target the same bank.
  always_comb begin
    bankStateNext[0] = bankState[0];
    bankStateNext[1] = bankState[1];
    wrBankNext       = wrBank;
    rdBankNext       = rdBank;
    wrRowNext        = wrRow;
    rdRowNext        = rdRow;
    tilesDoneNext    = tiles_done;

    if (clear) begin
      bankStateNext[0] = EMPTY;
      bankStateNext[1] = EMPTY;
      wrBankNext       = 1'b0;
      rdBankNext       = 1'b0;
      wrRowNext        = '0;
      rdRowNext        = '0;
    end else begin
      if (inXfer) begin
        wrRowNext = wrRow + IDX_W'(1);
        if (wrRow == LAST_ROW) begin
          bankStateNext[wrBank] = FULL;
          wrBankNext            = !wrBank;
        end else begin
          bankStateNext[wrBank] = FILLING;
        end
      end
      if (outXfer) begin
        rdRowNext = rdRow + IDX_W'(1);
        if (rdRow == LAST_ROW) begin
          bankStateNext[rdBank] = EMPTY;
          rdBankNext            = !rdBank;
          tilesDoneNext         = tiles_done + 16'd1;
        end else begin
          bankStateNext[rdBank] = DRAINING;
        end
      end
    end
  end

  // Row storage; not reset and not cleared, contents gated by bank state.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[wrBank][wrRow] <= bus.in_row;
    end
  end
endmodule

// File: tb/tb_tile_c_buffer.sv
module tb_tile_c_buffer;
  localparam int unsigned ROWS  = 16;
  localparam int unsigned ROW_W = 512;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [15:0] tiles_done;

  tile_c_buffer_if #(.ROWS(ROWS), .ROW_W(ROW_W)) bus ();

  tile_c_buffer #(.ROWS(ROWS), .ROW_W(ROW_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bus        (bus),
    .tiles_done (tiles_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: rows waiting at the producer, rows of the tile being
  // filled, and rows of completed tiles not yet drained (oldest first).
  logic [ROW_W-1:0] srcQ  [$];
  logic [ROW_W-1:0] partQ [$];
  logic [ROW_W-1:0] fullQ [$];
  logic [15:0]      tilesDone;

  int passCnt  = 0;
  int totalCnt = 0;

  task automatic chk(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    totalCnt++;
    assert (got === exp) passCnt++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [ROW_W-1:0] randRow();
    logic [ROW_W-1:0] r;
    for (int w = 0; w < ROW_W / 32; w++) r[w*32 +: 32] = $urandom();
    return r;
  endfunction

  // One clock cycle: drive at the negedge, check, advance the model, step.
  task automatic tick(input bit outR, input bit clr);
    int  sz, fullTiles, pos;
    bit  expInReady, expOutValid;
    bus.in_valid  = (srcQ.size() > 0);
    bus.in_row    = (srcQ.size() > 0) ? srcQ[0] : '0;
    bus.out_ready = outR;
    clear         = clr;
    #1;
    sz          = fullQ.size();
    fullTiles   = (sz + ROWS - 1) / ROWS;
    pos         = (ROWS - (sz % ROWS)) % ROWS;
    expInReady  = (fullTiles < 2);
    expOutValid = (fullTiles > 0);
    chk("in_ready",   ROW_W'(bus.in_ready),  ROW_W'(expInReady));
    chk("out_valid",  ROW_W'(bus.out_valid), ROW_W'(expOutValid));
    chk("out_idx",    ROW_W'(bus.out_idx),   ROW_W'(pos));
    chk("out_last",   ROW_W'(bus.out_last),  ROW_W'(expOutValid && pos == ROWS - 1));
    chk("tiles_done", ROW_W'(tiles_done),    ROW_W'(tilesDone));
    if (expOutValid) chk("out_row", bus.out_row, fullQ[0]);
    if (clr) begin
      partQ.delete();
      fullQ.delete();
    end else begin
      if (expOutValid && outR) begin
        void'(fullQ.pop_front());
        if (fullQ.size() % ROWS == 0) tilesDone++;
      end
      if (bus.in_valid && expInReady) begin
        partQ.push_back(srcQ.pop_front());
        if (partQ.size() == ROWS) begin
          foreach (partQ[i]) fullQ.push_back(partQ[i]);
          partQ.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic runUntilIdle(input int budget, input bit randReady);
    while (budget > 0 && (srcQ.size() > 0 || fullQ.size() > 0)) begin
      tick(randReady ? bit'($urandom_range(0, 1)) : 1'b1, 1'b0);
      budget--;
    end
    if (srcQ.size() > 0 || fullQ.size() > 0) begin
      totalCnt++;
      $error("FAIL drain_timeout got=%0d rows pending exp=0", srcQ.size() + fullQ.size());
    end
    chk("idle_out_valid", ROW_W'(bus.out_valid), ROW_W'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] r16;
    logic [15:0] savedDone;
    rst           = 1'b0;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    tilesDone     = '0;
    #1;
    chk("rst_in_ready",   ROW_W'(bus.in_ready),  ROW_W'(1));
    chk("rst_out_valid",  ROW_W'(bus.out_valid), ROW_W'(0));
    chk("rst_out_last",   ROW_W'(bus.out_last),  ROW_W'(0));
    chk("rst_out_idx",    ROW_W'(bus.out_idx),   ROW_W'(0));
    chk("rst_tiles_done", ROW_W'(tiles_done),    ROW_W'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Single tile with lane value = row index, consumer always ready.
    for (int r = 0; r < ROWS; r++) begin
      r16 = 16'(r);
      srcQ.push_back({32{r16}});
    end
    for (int c = 0; c < ROWS; c++) tick(1'b1, 1'b0);
    chk("t1_first_valid", ROW_W'(bus.out_valid), ROW_W'(1));
    runUntilIdle(100, 1'b0);
    chk("t1_tiles_done", ROW_W'(tiles_done), ROW_W'(1));

    // Back-pressure: 40 offered rows with a stalled consumer, 32 fit.
    for (int r = 0; r < 40; r++) srcQ.push_back(randRow());
    for (int c = 0; c < 45; c++) tick(1'b0, 1'b0);
    chk("t2_in_ready_low", ROW_W'(bus.in_ready), ROW_W'(0));
    chk("t2_held_rows",    ROW_W'(srcQ.size()),  ROW_W'(8));
    runUntilIdle(200, 1'b0);
    // The 8 leftover rows form a partial tile; complete it.
    for (int r = 0; r < 8; r++) srcQ.push_back(randRow());
    runUntilIdle(100, 1'b0);
    chk("t2_tiles_done", ROW_W'(tiles_done), ROW_W'(4));

    // Continuous streaming of 8 tiles: 16 fill cycles + 128 drain cycles.
    for (int r = 0; r < 8 * ROWS; r++) srcQ.push_back(randRow());
    for (int c = 0; c < 8 * ROWS + ROWS; c++) tick(1'b1, 1'b0);
    chk("t3_done_valid", ROW_W'(bus.out_valid), ROW_W'(0));
    chk("t3_tiles_done", ROW_W'(tiles_done),    ROW_W'(12));

    // Random consumer stalls over 3 tiles.
    for (int r = 0; r < 3 * ROWS; r++) srcQ.push_back(randRow());
    runUntilIdle(1000, 1'b1);
    chk("t4_tiles_done", ROW_W'(tiles_done), ROW_W'(15));

    // Partial tile discarded by clear; clear wins over a same-cycle input.
    for (int r = 0; r < 7; r++) srcQ.push_back(randRow());
    for (int c = 0; c < 7; c++) tick(1'b1, 1'b0);
    for (int r = 0; r < ROWS; r++) srcQ.push_back(randRow());
    savedDone = tiles_done;
    tick(1'b1, 1'b1);
    chk("t5_clear_keeps_done", ROW_W'(tiles_done), ROW_W'(savedDone));
    chk("t5_clear_held_row",   ROW_W'(srcQ.size()), ROW_W'(ROWS));
    runUntilIdle(100, 1'b0);
    chk("t5_tiles_done", ROW_W'(tiles_done), ROW_W'(16));

    // Asynchronous reset while row 5 is being presented.
    for (int r = 0; r < ROWS; r++) srcQ.push_back(randRow());
    for (int c = 0; c < ROWS + 5; c++) tick(1'b1, 1'b0);
    chk("t6_pre_idx", ROW_W'(bus.out_idx), ROW_W'(5));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid",  ROW_W'(bus.out_valid), ROW_W'(0));
    chk("t6_rst_in_ready",   ROW_W'(bus.in_ready),  ROW_W'(1));
    chk("t6_rst_tiles_done", ROW_W'(tiles_done),    ROW_W'(0));
    chk("t6_rst_out_idx",    ROW_W'(bus.out_idx),   ROW_W'(0));
    partQ.delete();
    fullQ.delete();
    tilesDone = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++) srcQ.push_back(randRow());
    runUntilIdle(100, 1'b0);
    chk("t6_tiles_done", ROW_W'(tiles_done), ROW_W'(1));

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule
